// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, DR select, opcodes, IR capture pattern
// and the 1149.1 next-state rule.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0, EX1_DR   = 4'h1, SH_DR    = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EX2_IR   = 4'h8, EX1_IR   = 4'h9, SH_IR    = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BSR    = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BYPASS = 2'd2
  } dr_sel_e;

  localparam int unsigned OP_EXTEST = 0;
  localparam int unsigned OP_SAMPLE = 1;
  localparam int unsigned OP_IDCODE = 2;
  localparam int unsigned OP_INTEST = 3;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:      return tms ? TLR    : RTI;
      RTI:      return tms ? SEL_DR : RTI;
      SEL_DR:   return tms ? SEL_IR : CAP_DR;
      CAP_DR:   return tms ? EX1_DR : SH_DR;
      SH_DR:    return tms ? EX1_DR : SH_DR;
      EX1_DR:   return tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: return tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   return tms ? UPD_DR : SH_DR;
      UPD_DR:   return tms ? SEL_DR : RTI;
      SEL_IR:   return tms ? TLR    : CAP_IR;
      CAP_IR:   return tms ? EX1_IR : SH_IR;
      SH_IR:    return tms ? EX1_IR : SH_IR;
      EX1_IR:   return tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: return tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   return tms ? UPD_IR : SH_IR;
      UPD_IR:   return tms ? SEL_DR : RTI;
      default:  return TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; strobes are registered alongside the state so each
// one is high exactly while the controller sits in the matching state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr
);

  tap_state_e nxt_c;

  assign nxt_c = tap_next(state, tms);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state      <= TLR;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
      capture_ir <= 1'b0;
      shift_ir   <= 1'b0;
      update_ir  <= 1'b0;
      tlr        <= 1'b1;
    end else begin
      state      <= nxt_c;
      capture_dr <= (nxt_c == CAP_DR);
      shift_dr   <= (nxt_c == SH_DR);
      update_dr  <= (nxt_c == UPD_DR);
      capture_ir <= (nxt_c == CAP_IR);
      shift_ir   <= (nxt_c == SH_IR);
      update_ir  <= (nxt_c == UPD_IR);
      tlr        <= (nxt_c == TLR);
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP for the adder DFT wrapper: IR, IDCODE/BYPASS/BSR data registers,
// falling-edge update latches and falling-edge TDO retiming.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 4,
  parameter int unsigned BSR_LEN      = 51,
  parameter logic [31:0] IDCODE_VALUE = 32'h0A5C_0001
) (
  input  logic                TCK,
  input  logic                TRST_N,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  input  logic [BSR_LEN-1:0]  bsr_capture,
  output logic [BSR_LEN-1:0]  bsr_update,
  output logic                test_mode,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] instr
);

  localparam logic [31:0]         ID_WORD   = IDCODE_VALUE | 32'h1;
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_WIDTH'(IR_CAPTURE);
  localparam logic [IR_WIDTH-1:0] OPC_EXT   = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] OPC_SMP   = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] OPC_ID    = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] OPC_INT   = IR_WIDTH'(OP_INTEST);

  tap_state_e          state;
  logic                capture_dr, shift_dr, update_dr;
  logic                capture_ir, shift_ir, update_ir, tlr;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] instr_nxt_c;
  logic [31:0]         id_shift;
  logic                byp_shift;
  logic [BSR_LEN-1:0]  bsr_shift;
  dr_sel_e             dr_sel_c;
  logic                tdo_nxt_c;

  jtag_tap_fsm u_fsm (
    .tck        (TCK),
    .trst_n     (TRST_N),
    .tms        (TMS),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .tlr        (tlr)
  );

  assign tap_state = state;

  // Unlisted opcodes fall through to BYPASS
  always_comb begin
    dr_sel_c = DR_BYPASS;
    if (instr == OPC_ID)
      dr_sel_c = DR_IDCODE;
    else if (instr == OPC_EXT || instr == OPC_SMP || instr == OPC_INT)
      dr_sel_c = DR_BSR;
  end

  always_comb begin
    instr_nxt_c = instr;
    if (tlr)
      instr_nxt_c = OPC_ID;
    else if (update_ir)
      instr_nxt_c = ir_shift;
  end

  always_comb begin
    tdo_nxt_c = 1'b0;
    if (shift_ir) begin
      tdo_nxt_c = ir_shift[0];
    end else if (shift_dr) begin
      case (dr_sel_c)
        DR_IDCODE: tdo_nxt_c = id_shift[0];
        DR_BYPASS: tdo_nxt_c = byp_shift;
        default:   tdo_nxt_c = bsr_shift[0];
      endcase
    end
  end

  // Capture/shift stages on the rising edge; only the selected DR moves
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_shift  <= IR_RESET;
      id_shift  <= '0;
      byp_shift <= 1'b0;
      bsr_shift <= '0;
    end else begin
      if (tlr || capture_ir)
        ir_shift <= IR_RESET;
      else if (shift_ir)
        ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};

      if (capture_dr) begin
        case (dr_sel_c)
          DR_IDCODE: id_shift  <= ID_WORD;
          DR_BYPASS: byp_shift <= 1'b0;
          default:   bsr_shift <= bsr_capture;
        endcase
      end else if (shift_dr) begin
        case (dr_sel_c)
          DR_IDCODE: id_shift  <= {TDI, id_shift[31:1]};
          DR_BYPASS: byp_shift <= TDI;
          default:   bsr_shift <= {TDI, bsr_shift[BSR_LEN-1:1]};
        endcase
      end
    end
  end

  // Update latches and TDO retiming on the falling edge
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      instr      <= OPC_ID;
      test_mode  <= 1'b0;
      bsr_update <= '0;
      TDO        <= 1'b0;
      TDO_EN     <= 1'b0;
    end else begin
      instr     <= instr_nxt_c;
      test_mode <= (instr_nxt_c == OPC_EXT) || (instr_nxt_c == OPC_INT);
      if (update_dr && dr_sel_c == DR_BSR)
        bsr_update <= bsr_shift;
      TDO    <= tdo_nxt_c;
      TDO_EN <= shift_dr | shift_ir;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: vector table for the IDCODE read, directed corner
// sequences, then random TMS/TDI against a queue-based TAP reference model.
module tb_jtag_tap_ctrl;

  localparam int unsigned IRW = 4;
  localparam int unsigned BSR = 51;
  localparam logic [31:0] EXP_ID = 32'h0A5C_0001;

  localparam int S_EX2DR = 0,  S_EX1DR = 1,  S_SHDR = 2,    S_PAUSEDR = 3;
  localparam int S_SELIR = 4,  S_UPDDR = 5,  S_CAPDR = 6,   S_SELDR = 7;
  localparam int S_EX2IR = 8,  S_EX1IR = 9,  S_SHIR = 10,   S_PAUSEIR = 11;
  localparam int S_RTI = 12,   S_UPDIR = 13, S_CAPIR = 14,  S_TLR = 15;

  logic           TCK = 1'b0;
  logic           TRST_N = 1'b1;
  logic           TMS = 1'b1;
  logic           TDI = 1'b0;
  logic           TDO, TDO_EN, test_mode;
  logic [BSR-1:0] bsr_capture = '0;
  logic [BSR-1:0] bsr_update;
  logic [3:0]     tap_state;
  logic [IRW-1:0] instr;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_tap_ctrl #(.IR_WIDTH(IRW), .BSR_LEN(BSR), .IDCODE_VALUE(32'h0A5C_0001)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .bsr_capture(bsr_capture), .bsr_update(bsr_update), .test_mode(test_mode),
    .tap_state(tap_state), .instr(instr)
  );

  always #5 TCK = ~TCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: TAP graph table, shift registers as bit queues (front = LSB)
  int             nxt_tab[16][2];
  int             ms;
  bit             irq[$];
  bit             dq[$];
  logic [IRW-1:0] m_instr;
  logic [BSR-1:0] m_bsr_upd;
  logic           m_tdo, m_en, m_tm;

  function automatic bit op_is_bsr(input logic [IRW-1:0] op);
    return op == 0 || op == 1 || op == 3;
  endfunction

  task automatic model_ir_capture();
    irq.delete();
    for (int i = 0; i < IRW; i++) irq.push_back(i == 0);
  endtask

  task automatic model_reset();
    ms = S_TLR;
    model_ir_capture();
    dq.delete();
    m_instr = 4'd2; m_bsr_upd = '0; m_tdo = 1'b0; m_en = 1'b0; m_tm = 1'b0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    case (ms)
      S_TLR, S_CAPIR: model_ir_capture();
      S_SHIR: begin void'(irq.pop_front()); irq.push_back(tdi); end
      S_CAPDR: begin
        dq.delete();
        if (m_instr == 4'd2) for (int i = 0; i < 32; i++) dq.push_back(EXP_ID[i]);
        else if (op_is_bsr(m_instr)) for (int i = 0; i < BSR; i++) dq.push_back(bsr_capture[i]);
        else dq.push_back(1'b0);
      end
      S_SHDR: begin void'(dq.pop_front()); dq.push_back(tdi); end
      default: ;
    endcase
    ms = nxt_tab[ms][tms ? 1 : 0];
  endtask

  task automatic model_fall();
    if (ms == S_TLR) m_instr = 4'd2;
    else if (ms == S_UPDIR) for (int i = 0; i < IRW; i++) m_instr[i] = irq[i];
    if (ms == S_UPDDR && op_is_bsr(m_instr))
      for (int i = 0; i < BSR; i++) m_bsr_upd[i] = dq[i];
    m_tdo = (ms == S_SHDR) ? dq[0] : (ms == S_SHIR) ? irq[0] : 1'b0;
    m_en  = (ms == S_SHDR) || (ms == S_SHIR);
    m_tm  = (m_instr == 4'd0) || (m_instr == 4'd3);
  endtask

  task automatic compare_model();
    check("tap_state",  64'(tap_state),  64'(ms));
    check("instr",      64'(instr),      64'(m_instr));
    check("tdo",        64'(TDO),        64'(m_tdo));
    check("tdo_en",     64'(TDO_EN),     64'(m_en));
    check("test_mode",  64'(test_mode),  64'(m_tm));
    check("bsr_update", 64'(bsr_update), 64'(m_bsr_upd));
  endtask

  // One TCK cycle; outputs sampled just after the falling edge
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    @(posedge TCK);
    model_rise(tms, tdi);
    @(negedge TCK);
    model_fall();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    TRST_N = 1'b0;
    #1;
    model_reset();
    compare_model();
    #1;
    TRST_N = 1'b1;
  endtask

  task automatic load_ir(input logic [IRW-1:0] v);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) tick(i == IRW - 1, v[i]);
    tick(1, 0);
    check("load_ir_instr", 64'(instr), 64'(v));
    tick(0, 0);
  endtask

  task automatic shift_dr(input int n, input logic [63:0] data, output logic [63:0] out);
    out = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      out[i] = TDO;
      tick(i == n - 1, data[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       tdo;
    logic       en;
  } vec_t;

  vec_t vt[36];

  initial begin
    int rows[16][3];
    logic [63:0] out;
    rows = '{'{S_TLR, S_RTI, S_TLR},       '{S_RTI, S_RTI, S_SELDR},
             '{S_SELDR, S_CAPDR, S_SELIR}, '{S_CAPDR, S_SHDR, S_EX1DR},
             '{S_SHDR, S_SHDR, S_EX1DR},   '{S_EX1DR, S_PAUSEDR, S_UPDDR},
             '{S_PAUSEDR, S_PAUSEDR, S_EX2DR}, '{S_EX2DR, S_SHDR, S_UPDDR},
             '{S_UPDDR, S_RTI, S_SELDR},   '{S_SELIR, S_CAPIR, S_TLR},
             '{S_CAPIR, S_SHIR, S_EX1IR},  '{S_SHIR, S_SHIR, S_EX1IR},
             '{S_EX1IR, S_PAUSEIR, S_UPDIR}, '{S_PAUSEIR, S_PAUSEIR, S_EX2IR},
             '{S_EX2IR, S_SHIR, S_UPDIR},  '{S_UPDIR, S_RTI, S_SELDR}};
    for (int i = 0; i < 16; i++) begin
      nxt_tab[rows[i][0]][0] = rows[i][1];
      nxt_tab[rows[i][0]][1] = rows[i][2];
    end

    // IDCODE read vectors: navigate to ShDR, then 32 bits LSB-first
    vt[0] = '{1'b0, 1'b0, 4'(S_RTI),   1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 4'(S_SELDR), 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 4'(S_CAPDR), 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 4'(S_SHDR),  EXP_ID[0], 1'b1};
    for (int i = 0; i < 31; i++) vt[4 + i] = '{1'b0, 1'b0, 4'(S_SHDR), EXP_ID[i + 1], 1'b1};
    vt[35] = '{1'b1, 1'b0, 4'(S_EX1DR), 1'b0, 1'b0};

    #1;
    do_reset();

    for (int i = 0; i < 36; i++) begin
      tick(vt[i].tms, vt[i].tdi);
      check("vec_state", 64'(tap_state), 64'(vt[i].st));
      check("vec_tdo",   64'(TDO),       64'(vt[i].tdo));
      check("vec_tdo_en", 64'(TDO_EN),   64'(vt[i].en));
    end
    tick(1, 0); tick(0, 0);

    // Bypass with all-ones and with an unlisted opcode
    load_ir(4'hF);
    shift_dr(9, 64'h0B2, out);
    check("bypass_f_stream", out, 64'h164);
    load_ir(4'h9);
    check("bypass_9_test_mode", 64'(test_mode), 64'h0);
    shift_dr(9, 64'h0B2, out);
    check("bypass_9_stream", out, 64'h164);

    // TLR recovery from PauseIR
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(1, 1); tick(0, 0);
    check("pause_ir_state", 64'(tap_state), 64'(S_PAUSEIR));
    for (int i = 0; i < 5; i++) begin
      tick(1, 0);
      if (i == 3) check("tlr_4th_not_tlr", 64'(tap_state == 4'(S_TLR)), 64'h0);
    end
    check("tlr_5th_state", 64'(tap_state), 64'(S_TLR));
    check("tlr_5th_instr", 64'(instr), 64'h2);
    tick(0, 0);

    // SAMPLE/PRELOAD, then EXTEST
    bsr_capture = 51'h5_5555_5555_5555;
    load_ir(4'h1);
    shift_dr(51, 64'h2_AAAA_AAAA_AAAA, out);
    check("sample_stream", out, 64'h5_5555_5555_5555);
    check("preload_update", 64'(bsr_update), 64'h2_AAAA_AAAA_AAAA);
    check("sample_test_mode", 64'(test_mode), 64'h0);
    load_ir(4'h0);
    check("extest_test_mode", 64'(test_mode), 64'h1);
    check("extest_update", 64'(bsr_update), 64'h2_AAAA_AAAA_AAAA);

    // TRST_N mid-shift
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1'(i));
    TRST_N = 1'b0;
    #1;
    check("rst_state",     64'(tap_state),  64'(S_TLR));
    check("rst_instr",     64'(instr),      64'h2);
    check("rst_bsr_update", 64'(bsr_update), 64'h0);
    check("rst_tdo",       64'(TDO),        64'h0);
    check("rst_tdo_en",    64'(TDO_EN),     64'h0);
    check("rst_test_mode", 64'(test_mode),  64'h0);
    model_reset();
    #1;
    TRST_N = 1'b1;

    // Random walk against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) bsr_capture = BSR'({$urandom, $urandom});
      if ($urandom_range(0, 599) == 0) do_reset();
      tick($urandom_range(0, 99) < 30, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
